// File: rtl/uart_receiver.sv
// UART receive stage: oversampled serial-to-parallel conversion.
// Frame: start(0), DATA_WIDTH data bits LSB first, optional even parity, stop(1).
// Recovered byte and status flags are held until the next completed frame.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling start edge (gated by rx_enable)
// START  | counting to mid start bit to reject glitches
// DATA   | sampling data bits at each bit period, shifting in LSB first
// PARITY | sampling the even-parity bit
// STOP   | sampling the stop bit, publishing the frame result
// BREAK  | stop bit was low; wait for the line to return high
module uart_receiver #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  rx_clk,
   input  logic                  rst,
   input  logic                  rx_enable,
   input  logic                  parity_enable,
   input  logic                  rx_data_in,
   output logic [DATA_WIDTH-1:0] rx_data_out,
   output logic                  rx_done,
   output logic                  parity_error,
   output logic                  framing_error,
   output logic                  busy
);

   localparam int SC_W = $clog2(OVERSAMPLE);
   localparam int BC_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [SC_W-1:0] SAMP_MID = SC_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SC_W-1:0] SAMP_END = SC_W'(OVERSAMPLE - 1);
   localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            sync_q;
   logic                  line;
   logic [SC_W-1:0]       samp_cnt_q, samp_cnt_d;
   logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  cfg_parity_q, cfg_parity_d;
   logic                  par_err_q, par_err_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  done_q, done_d;
   logic                  perr_q, perr_d;
   logic                  ferr_q, ferr_d;

   // Two-flop synchronizer; the line idles high so reset to 1 avoids a false start.
   always_ff @(posedge rx_clk) begin
      if (rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx_data_in};
      end
   end

   assign line = sync_q[1];

   // State and datapath registers.
   always_ff @(posedge rx_clk) begin
      if (rst) begin
         state_q      <= IDLE;
         samp_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         cfg_parity_q <= 1'b0;
         par_err_q    <= 1'b0;
         data_q       <= '0;
         done_q       <= 1'b0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         samp_cnt_q   <= samp_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         cfg_parity_q <= cfg_parity_d;
         par_err_q    <= par_err_d;
         data_q       <= data_d;
         done_q       <= done_d;
         perr_q       <= perr_d;
         ferr_q       <= ferr_d;
      end
   end

   // Next-state and datapath updates; rx_done is a registered one-cycle pulse.
   always_comb begin
      state_d      = state_q;
      samp_cnt_d   = samp_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      cfg_parity_d = cfg_parity_q;
      par_err_d    = par_err_q;
      data_d       = data_q;
      done_d       = 1'b0;
      perr_d       = perr_q;
      ferr_d       = ferr_q;

      case (state_q)
         IDLE: begin
            if (rx_enable && !line) begin
               cfg_parity_d = parity_enable;
               par_err_d    = 1'b0;
               samp_cnt_d   = '0;
               state_d      = START;
            end
         end

         START: begin
            if (samp_cnt_q == SAMP_MID) begin
               samp_cnt_d = '0;
               if (line) begin
                  state_d = IDLE;
               end else begin
                  bit_cnt_d = '0;
                  state_d   = DATA;
               end
            end else begin
               samp_cnt_d = samp_cnt_q + 1'b1;
            end
         end

         DATA: begin
            if (samp_cnt_q == SAMP_END) begin
               samp_cnt_d = '0;
               shift_d    = {line, shift_q[DATA_WIDTH-1:1]};
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = cfg_parity_q ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               samp_cnt_d = samp_cnt_q + 1'b1;
            end
         end

         PARITY: begin
            if (samp_cnt_q == SAMP_END) begin
               samp_cnt_d = '0;
               par_err_d  = line ^ (^shift_q);
               state_d    = STOP;
            end else begin
               samp_cnt_d = samp_cnt_q + 1'b1;
            end
         end

         STOP: begin
            if (samp_cnt_q == SAMP_END) begin
               samp_cnt_d = '0;
               data_d     = shift_q;
               perr_d     = cfg_parity_q & par_err_q;
               ferr_d     = ~line;
               done_d     = 1'b1;
               state_d    = line ? IDLE : BREAK;
            end else begin
               samp_cnt_d = samp_cnt_q + 1'b1;
            end
         end

         BREAK: begin
            if (line) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rx_data_out   = data_q;
   assign rx_done       = done_q;
   assign parity_error  = perr_q;
   assign framing_error = ferr_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are driven bit by bit, the
// expected result is queued at send time and a monitor checks each rx_done.
module tb_uart_receiver;

   localparam int OS = 16;

   logic       rx_clk;
   logic       rst;
   logic       rx_enable;
   logic       parity_enable;
   logic       rx_data_in;
   logic [7:0] rx_data_out;
   logic       rx_done;
   logic       parity_error;
   logic       framing_error;
   logic       busy;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   int   done_cnt = 0;
   logic prev_done = 1'b0;

   uart_receiver #(.OVERSAMPLE(OS), .DATA_WIDTH(8)) dut (
      .rx_clk        (rx_clk),
      .rst           (rst),
      .rx_enable     (rx_enable),
      .parity_enable (parity_enable),
      .rx_data_in    (rx_data_in),
      .rx_data_out   (rx_data_out),
      .rx_done       (rx_done),
      .parity_error  (parity_error),
      .framing_error (framing_error),
      .busy          (busy)
   );

   initial rx_clk = 1'b0;
   always #5 rx_clk = ~rx_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic drive_bit(input logic b);
      rx_data_in = b;
      repeat (OS) @(negedge rx_clk);
   endtask

   // Sends one frame; when expect_done is set the result is queued first.
   task automatic send_frame(input logic [7:0] d, input logic with_par, input logic par_bit,
                             input logic stop_bit, input logic exp_perr, input logic expect_done);
      exp_t e;
      if (expect_done) begin
         e.data = d;
         e.perr = exp_perr;
         e.ferr = ~stop_bit;
         e.busy = ~stop_bit;
         exp_q.push_back(e);
      end
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (with_par) drive_bit(par_bit);
      drive_bit(stop_bit);
   endtask

   task automatic idle(input int n);
      rx_data_in = 1'b1;
      repeat (n) @(negedge rx_clk);
   endtask

   // Monitor: pops the scoreboard on each rx_done and checks pulse width.
   always @(negedge rx_clk) begin
      exp_t e;
      if (prev_done) check("done_pulse_width", {31'd0, rx_done}, 32'd0);
      if (rx_done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("rx_data_out", {24'd0, rx_data_out}, {24'd0, e.data});
            check("parity_error", {31'd0, parity_error}, {31'd0, e.perr});
            check("framing_error", {31'd0, framing_error}, {31'd0, e.ferr});
            check("busy_at_done", {31'd0, busy}, {31'd0, e.busy});
         end
      end
      prev_done = rx_done;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d55;
      rst           = 1'b1;
      rx_enable     = 1'b1;
      parity_enable = 1'b1;
      rx_data_in    = 1'b1;
      repeat (3) @(negedge rx_clk);
      check("reset_data", {24'd0, rx_data_out}, 32'd0);
      check("reset_done", {31'd0, rx_done}, 32'd0);
      check("reset_perr", {31'd0, parity_error}, 32'd0);
      check("reset_ferr", {31'd0, framing_error}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      idle(5);

      // Parity on: good frame, bad parity, then a good frame clearing the flag.
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      idle(10);
      check("busy_after_A5", {31'd0, busy}, 32'd0);
      send_frame(8'h19, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(10);
      send_frame(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      idle(10);

      // Stop bit low followed by a held-low line.
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      rx_data_in = 1'b0;
      repeat (40) @(negedge rx_clk);
      check("busy_in_break", {31'd0, busy}, 32'd1);
      idle(5);
      check("busy_after_break", {31'd0, busy}, 32'd0);
      idle(10);

      // Short low glitch must be rejected in START.
      rx_data_in = 1'b0;
      repeat (4) @(negedge rx_clk);
      idle(30);
      check("glitch_data", {24'd0, rx_data_out}, 32'h3C);
      check("glitch_perr", {31'd0, parity_error}, 32'd0);
      check("glitch_ferr", {31'd0, framing_error}, 32'd1);
      check("glitch_busy", {31'd0, busy}, 32'd0);

      // Receiver disabled: a full frame must be ignored.
      rx_enable = 1'b0;
      send_frame(8'hAA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(10);
      check("disabled_busy", {31'd0, busy}, 32'd0);
      check("disabled_data", {24'd0, rx_data_out}, 32'h3C);
      rx_enable = 1'b1;

      // Parity off, back-to-back frames.
      parity_enable = 1'b0;
      send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      idle(20);

      // Reset during the 4th data bit of 0x55 aborts silently.
      parity_enable = 1'b1;
      d55 = 8'h55;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(d55[i]);
      rx_data_in = d55[3];
      repeat (8) @(negedge rx_clk);
      rst = 1'b1;
      @(negedge rx_clk);
      check("midrst_data", {24'd0, rx_data_out}, 32'd0);
      check("midrst_perr", {31'd0, parity_error}, 32'd0);
      check("midrst_ferr", {31'd0, framing_error}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      idle(40);
      check("midrst_busy_after", {31'd0, busy}, 32'd0);

      send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      idle(30);

      check("pending_expected", exp_q.size(), 32'd0);
      check("done_count", done_cnt, 32'd7);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
